wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares one scoreboard write-back port among the variable-latency execute units: multiplier/divider, FPU and bit-manipulation unit. Each unit hands over its result through a valid/ready handshake into a single-entry holding slot. A round-robin arbiter drains one slot per cycle onto the shared write-back port. The block sits between the execute-stage units and the scoreboard write-back inputs, and its flush clears in-flight results on a pipeline flush.

## Interface
Parameters:
- NrReq, 3, number of requesters; index 0 = mult, 1 = FPU, 2 = bitmanip; legal range 2..8
- IdxW, $clog2(NrReq), width of the source index

Ports (reset is synchronous and active-high; one clock):
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  drop all held and incoming results
- req_valid_i  in  NrReq  per-requester result valid
- req_ready_o  out  NrReq  per-requester slot can accept
- req_data_i  in  NrReq x wb_entry_t  per-requester trans_id (TRANS_ID_BITS), result (64), exception (exception_t)
- wb_valid_o  out  1  write-back valid; the scoreboard always accepts
- wb_data_o  out  wb_entry_t  granted entry; all-zero when wb_valid_o=0
- wb_src_o  out  IdxW  index of the granted requester; 0 when idle
- busy_o  out  1  at least one slot full

## Operation
State:
- per requester i: slot full bit full[i] and one wb_entry_t register
- rr_ptr (IdxW bits), the highest-priority index

Arbitration:
- Combinational search over full[] starting at rr_ptr, ascending, wrapping NrReq-1 to 0.
- The first full slot wins: grant[i]=1, wb_valid_o=1, and wb_data_o/wb_src_o are driven from that slot.

Slot update, per i, each cycle without flush or reset:
- req_ready_o[i] = !full[i] | grant[i] (a granted slot accepts again in the same cycle).
- full[i] next = (req_valid_i[i] & req_ready_o[i]) | (full[i] & !grant[i]).
- On accept, the slot register loads req_data_i[i].

Pointer:
- On any grant to index g, rr_ptr next = (g==NrReq-1) ? 0 : g+1.
- With no grant, rr_ptr holds.

Flush:
- full[] next = 0 and rr_ptr holds.
- req_ready_o stays as computed; any input accepted in the flush cycle is discarded.
- wb_valid_o is still driven in the flush cycle (combinational from current slots). The scoreboard ignores write-back under flush.

Reset:
- full[]=0, rr_ptr=0, slot data=0.
- wb_valid_o=0, wb_data_o=0, wb_src_o=0, busy_o=0.
- req_ready_o = all ones.
- Reset takes priority over flush and over a simultaneous accept.

Width rules:
- No arithmetic beyond the pointer increment; the pointer wraps explicitly, not via modulo of a non-power-of-two.
- wb_data_o is AND-gated with wb_valid_o (data silencing).

## Timing
- Latency: a result accepted at edge N is visible on wb_* in cycle N+1 when uncontended. Worst case is N+NrReq under full contention.
- Throughput: one write-back per cycle; one acceptance per requester per cycle.
- A requester must hold req_valid_i and req_data_i stable until it sees req_ready_o high.
- req_ready_o depends combinationally on full[] and the grant only, never on req_valid_i.
- No combinational path from req_valid_i or req_data_i to any wb_* output.
- busy_o = OR of full[], a registered-state function.

## Structure
- The wb_entry_t typedef (trans_id, result, exception) goes in ariane_pkg next to exception_t and TRANS_ID_BITS.
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Reusable by other arbiters.
- Slot registers, flush handling and pointer update live in wb_port_arbiter.

## Test plan
- Reset, then req 1 valid with trans_id=5, result=0xDEAD, one cycle → next cycle wb_valid_o=1, wb_src_o=1, trans_id=5, result=0xDEAD. The cycle after: wb_valid_o=0 and wb_data_o=0.
- All three requesters valid in the same cycle with rr_ptr=0 → write-backs on three consecutive cycles with src 0,1,2; rr_ptr ends at 0; busy_o falls after the third.
- Requester 0 streams valid every cycle while requester 2 holds one entry, rr_ptr=0 → srcs alternate 0,2,0; req_ready_o[0] never drops while slot 0 is granted.
- Requester 2 granted → rr_ptr wraps to 0; a subsequent simultaneous req 0 and req 1 gives 0 then 1.
- Slots 0 and 1 full, flush_i pulsed while requester 2 offers data → next cycle full[]=0, wb_valid_o=0, busy_o=0; requester 2's data is never written back.
- rst_i asserted while two slots are full and a new accept occurs → next cycle all outputs are at reset values and rr_ptr=0.

Source files
------------

// File: rtl/ariane_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ariane_pkg: shared execute/write-back types (exception, wb entry)        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              result;
    exception_t               ex;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick: combinational round-robin picker, first set req at/after ptr    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_pick #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  // Two passes (indices >= ptr, then the wrapped-around lower part) avoid any
  // modulo arithmetic on a non-power-of-two requester count.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int j = 0; j < int'(N); j++) begin
      if (!any_o && req_i[j] && (IdxW'(j) >= ptr_i)) begin
        grant_o[j] = 1'b1;
        idx_o      = IdxW'(j);
        any_o      = 1'b1;
      end
    end
    for (int j = 0; j < int'(N); j++) begin
      if (!any_o && req_i[j]) begin
        grant_o[j] = 1'b1;
        idx_o      = IdxW'(j);
        any_o      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_port_arbiter: per-unit holding slots drained round-robin onto one     |
// | scoreboard write-back port, with pipeline flush. Revision: 1.0           |
// +--------------------------------------------------------------------------+
module wb_port_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NrReq = 3,
  parameter int unsigned IdxW  = $clog2(NrReq)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [NrReq-1:0]      req_valid_i,
  output logic [NrReq-1:0]      req_ready_o,
  input  wb_entry_t [NrReq-1:0] req_data_i,
  output logic                  wb_valid_o,
  output wb_entry_t             wb_data_o,
  output logic [IdxW-1:0]       wb_src_o,
  output logic                  busy_o
);

  logic [NrReq-1:0]      full_q;
  wb_entry_t [NrReq-1:0] slot_q;
  logic [IdxW-1:0]       rr_ptr_q;

  logic [NrReq-1:0]      grant;
  logic [IdxW-1:0]       pick_idx;
  logic                  pick_any;
  logic [NrReq-1:0]      accept;

  rr_pick #(
    .N    (NrReq),
    .IdxW (IdxW)
  ) u_pick (
    .req_i   (full_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // A slot being drained this cycle can refill in the same cycle.
  assign req_ready_o = ~full_q | grant;
  assign accept      = req_valid_i & req_ready_o;

  assign wb_valid_o = pick_any;
  assign wb_src_o   = pick_idx;
  assign wb_data_o  = slot_q[pick_idx] & {$bits(wb_entry_t){pick_any}};
  assign busy_o     = |full_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q   <= '0;
      slot_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      for (int i = 0; i < int'(NrReq); i++) begin
        if (accept[i]) slot_q[i] <= req_data_i[i];
      end
      if (flush_i) begin
        full_q <= '0;
      end else begin
        full_q <= accept | (full_q & ~grant);
        if (pick_any) begin
          rr_ptr_q <= (pick_idx == IdxW'(NrReq - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_port_arbiter: directed scenarios plus randomized model comparison  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wb_port_arbiter;
  import ariane_pkg::*;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  wb_entry_t [N-1:0] req_data;
  logic            wb_valid;
  wb_entry_t       wb_data;
  logic [1:0]      wb_src;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.NrReq(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .wb_valid_o  (wb_valid),
    .wb_data_o   (wb_data),
    .wb_src_o    (wb_src),
    .busy_o      (busy)
  );

  // Reference model: occupancy list, stored entries, and next-priority index.
  bit        m_full [N];
  wb_entry_t m_slot [N];
  int        m_ptr;

  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (m_full[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int g;
    bit acc [N];
    g = m_winner();
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_full[i] = 1'b0;
        m_slot[i] = '0;
      end
      m_ptr = 0;
    end else begin
      for (int i = 0; i < N; i++)
        acc[i] = req_valid[i] && (!m_full[i] || g == i);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) m_slot[i] = req_data[i];
        m_full[i] = flush ? 1'b0 : (acc[i] || (m_full[i] && g != i));
      end
      if (!flush && g >= 0) m_ptr = (g + 1) % N;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic wb_entry_t mk(input int tid, input logic [63:0] res);
    wb_entry_t e;
    e = '0;
    e.trans_id = tid[TRANS_ID_BITS-1:0];
    e.result   = res;
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_data = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%0b want=0", wb_valid); end
    total++; if (wb_data !== '0) begin bad++; $display("FAIL reset_wb_data got=%h want=0", wb_data); end
    total++; if (wb_src !== 2'd0) begin bad++; $display("FAIL reset_wb_src got=%0d want=0", wb_src); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (req_ready !== 3'b111) begin bad++; $display("FAIL reset_ready got=%b want=111", req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 3'b010;
    req_data[1] = mk(5, 64'hDEAD);
    step();
    req_valid = '0;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", wb_valid); end
    total++; if (wb_src !== 2'd1) begin bad++; $display("FAIL single_src got=%0d want=1", wb_src); end
    total++; if (wb_data.trans_id !== 3'd5) begin bad++; $display("FAIL single_tid got=%0d want=5", wb_data.trans_id); end
    total++; if (wb_data.result !== 64'hDEAD) begin bad++; $display("FAIL single_result got=%h want=dead", wb_data.result); end
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL single_after_valid got=%0b want=0", wb_valid); end
    total++; if (wb_data !== '0) begin bad++; $display("FAIL single_after_data got=%h want=0", wb_data); end
  endtask

  task automatic test_all_three_and_wrap();
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) req_data[i] = mk(i + 1, 64'(100 + i));
    step();
    req_valid = '0;
    for (int k = 0; k < N; k++) begin
      total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL all3_valid[%0d] got=%0b want=1", k, wb_valid); end
      total++; if (wb_src !== 2'(k)) begin bad++; $display("FAIL all3_src[%0d] got=%0d want=%0d", k, wb_src, k); end
      total++; if (wb_data !== mk(k + 1, 64'(100 + k))) begin bad++; $display("FAIL all3_data[%0d] got=%h want=%h", k, wb_data, mk(k + 1, 64'(100 + k))); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL all3_busy[%0d] got=%0b want=1", k, busy); end
      step();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL all3_busy_end got=%0b want=0", busy); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL all3_valid_end got=%0b want=0", wb_valid); end
    // Pointer wrapped after index 2, so 0 must beat 1.
    req_valid = 3'b011;
    req_data[0] = mk(3, 64'hA0);
    req_data[1] = mk(4, 64'hA1);
    step();
    req_valid = '0;
    total++; if (wb_src !== 2'd0 || wb_valid !== 1'b1) begin bad++; $display("FAIL wrap_first src=%0d valid=%0b want src=0 valid=1", wb_src, wb_valid); end
    step();
    total++; if (wb_src !== 2'd1 || wb_data !== mk(4, 64'hA1)) begin bad++; $display("FAIL wrap_second src=%0d data=%h want src=1", wb_src, wb_data); end
    step();
  endtask

  task automatic test_stream();
    do_reset();
    req_valid = 3'b101;
    req_data[0] = mk(0, 64'h1000);
    req_data[2] = mk(7, 64'h222);
    step();
    req_valid[2] = 1'b0;
    req_data[0] = mk(1, 64'h1001);
    total++; if (wb_src !== 2'd0 || wb_data !== mk(0, 64'h1000)) begin bad++; $display("FAIL stream_c1 src=%0d data=%h want src=0", wb_src, wb_data); end
    total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL stream_c1_ready0 got=%0b want=1", req_ready[0]); end
    step();
    req_data[0] = mk(2, 64'h1002);
    total++; if (wb_src !== 2'd2 || wb_data !== mk(7, 64'h222)) begin bad++; $display("FAIL stream_c2 src=%0d data=%h want src=2", wb_src, wb_data); end
    total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL stream_c2_ready0 got=%0b want=0", req_ready[0]); end
    step();
    total++; if (wb_src !== 2'd0 || wb_data !== mk(1, 64'h1001)) begin bad++; $display("FAIL stream_c3 src=%0d data=%h want src=0", wb_src, wb_data); end
    total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL stream_c3_ready0 got=%0b want=1", req_ready[0]); end
    req_valid = '0;
    step();
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 3'b011;
    req_data[0] = mk(1, 64'h10);
    req_data[1] = mk(2, 64'h20);
    step();
    req_valid = 3'b100;
    req_data[2] = mk(3, 64'hBAD);
    flush = 1'b1;
    total++; if (wb_valid !== 1'b1 || wb_src !== 2'd0) begin bad++; $display("FAIL flush_cycle valid=%0b src=%0d want valid=1 src=0", wb_valid, wb_src); end
    step();
    flush = 1'b0;
    req_valid = '0;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", wb_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%0b want=0", busy); end
    total++; if (req_ready !== 3'b111) begin bad++; $display("FAIL flush_ready got=%b want=111", req_ready); end
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL flush_req2_dropped valid=%0b want=0", wb_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 3'b011;
    req_data[0] = mk(1, 64'h30);
    req_data[1] = mk(2, 64'h31);
    step();
    rst = 1'b1;
    req_valid = 3'b100;
    req_data[2] = mk(6, 64'h66);
    step();
    rst = 1'b0;
    req_valid = '0;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b want=0", wb_valid); end
    total++; if (wb_data !== '0) begin bad++; $display("FAIL rstmid_data got=%h want=0", wb_data); end
    total++; if (wb_src !== 2'd0) begin bad++; $display("FAIL rstmid_src got=%0d want=0", wb_src); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b want=0", busy); end
    total++; if (req_ready !== 3'b111) begin bad++; $display("FAIL rstmid_ready got=%b want=111", req_ready); end
    req_valid = 3'b011;
    step();
    req_valid = '0;
    total++; if (wb_src !== 2'd0 || wb_valid !== 1'b1) begin bad++; $display("FAIL rstmid_ptr src=%0d valid=%0b want src=0 valid=1", wb_src, wb_valid); end
    step();
    step();
  endtask

  task automatic test_random();
    bit pending [N];
    do_reset();
    for (int i = 0; i < N; i++) pending[i] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      int        g;
      logic      e_valid;
      logic [1:0] e_src;
      wb_entry_t e_data;
      logic      e_busy;
      logic [N-1:0] e_ready;
      g       = m_winner();
      e_valid = (g >= 0);
      e_src   = (g >= 0) ? 2'(g) : 2'd0;
      e_data  = (g >= 0) ? m_slot[g] : '0;
      e_busy  = 1'b0;
      for (int i = 0; i < N; i++) begin
        e_busy     = e_busy | m_full[i];
        e_ready[i] = !m_full[i] || (g == i);
      end
      total++; if (wb_valid !== e_valid) begin bad++; $display("FAIL rand_valid c=%0d got=%0b want=%0b", c, wb_valid, e_valid); end
      total++; if (wb_src !== e_src) begin bad++; $display("FAIL rand_src c=%0d got=%0d want=%0d", c, wb_src, e_src); end
      total++; if (wb_data !== e_data) begin bad++; $display("FAIL rand_data c=%0d got=%h want=%h", c, wb_data, e_data); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL rand_busy c=%0d got=%0b want=%0b", c, busy, e_busy); end
      total++; if (req_ready !== e_ready) begin bad++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, req_ready, e_ready); end
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 1) begin
          wb_entry_t e;
          e.trans_id = TRANS_ID_BITS'($urandom);
          e.result   = {$urandom, $urandom};
          e.ex.cause = {$urandom, $urandom};
          e.ex.tval  = {$urandom, $urandom};
          e.ex.valid = 1'($urandom);
          req_data[i] = e;
          pending[i]  = 1'b1;
        end
        req_valid[i] = pending[i];
      end
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      step();
      for (int i = 0; i < N; i++)
        if (pending[i] && e_ready[i]) pending[i] = 1'b0;
    end
    rst = 1'b0; flush = 1'b0; req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_data = '0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_slot[i] = '0;
    end
    test_reset();
    test_single();
    test_all_three_and_wrap();
    test_stream();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
